// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, reset PC and
// instruction width.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned INST_W           = 32;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues req/ack word fetches to instruction
// memory, presents instructions under decode stall, applies redirects/halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc4,
  output logic              misalign,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;
  logic              halt_pend_q, halt_pend_d;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              outstanding;
  logic [ADDR_W-1:0] redir_aligned;

  assign redir_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_comb begin
    req  = 1'b0;
    addr = pc_q;
    unique case (state_q)
      ST_RUN:   req = !valid_q || !stall;
      ST_DRAIN: begin
        req  = 1'b1;
        addr = hold_addr_q;
      end
      default: ;
    endcase
  end

  assign outstanding = req && !imem_ack;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    inst_pc_d   = inst_pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    misalign_d  = 1'b0;
    halt_pend_d = halt_pend_q;

    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;

      ST_RUN: begin
        if (valid_q && !stall) valid_d = 1'b0;
        // A request already on the bus must finish before leaving RUN, so
        // halt and redirect both park in DRAIN with the old address held.
        if (halt) begin
          valid_d = 1'b0;
          if (outstanding) begin
            state_d     = ST_DRAIN;
            hold_addr_d = pc_q;
            halt_pend_d = 1'b1;
          end else begin
            state_d = ST_HALTED;
          end
        end else if (redirect_valid) begin
          valid_d    = 1'b0;
          pc_d       = redir_aligned;
          misalign_d = |redirect_pc[1:0];
          if (outstanding) begin
            state_d     = ST_DRAIN;
            hold_addr_d = pc_q;
          end
        end else if (req && imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + ADDR_W'(4);
        end
      end

      ST_DRAIN: begin
        if (halt) begin
          halt_pend_d = 1'b1;
        end else if (redirect_valid && !halt_pend_q) begin
          pc_d       = redir_aligned;
          misalign_d = |redirect_pc[1:0];
        end
        if (imem_ack) begin
          halt_pend_d = 1'b0;
          state_d     = (halt || halt_pend_q) ? ST_HALTED : ST_RUN;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      hold_addr_q <= '0;
      inst_pc_q   <= '0;
      inst_q      <= '0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      inst_pc_q   <= inst_pc_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign imem_req   = req;
  assign imem_addr  = addr;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_pc4   = inst_pc_q + ADDR_W'(4);
  assign misalign   = misalign_q;
  assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run checked
// against a program-order scoreboard and an address-derived memory image.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        misalign;
  logic        halted;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
    .misalign(misalign), .halted(halted)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    n_total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else n_pass++;
    n_total++; if (inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", inst); else n_pass++;
    n_total++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h want 0", inst_pc); else n_pass++;
    n_total++; if (inst_pc4 !== 32'h4) $display("FAIL reset_inst_pc4: got %h want 4", inst_pc4); else n_pass++;
    n_total++; if ({misalign, halted} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {misalign, halted}); else n_pass++;
  endtask

  task automatic test_stream();
    apply_reset();
    imem_ack = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", imem_req); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      next();
      #1;
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 + 32'(4 * i))
        $display("FAIL stream_addr%0d: got %b/%h want 1/%h", i, imem_req, imem_addr, 32'h3000 + 32'(4 * i)); else n_pass++;
      n_total++; if (inst_valid !== (i > 0)) $display("FAIL stream_valid%0d: got %b want %b", i, inst_valid, i > 0); else n_pass++;
      if (i > 0) begin
        n_total++; if (inst_pc !== 32'h3000 + 32'(4 * (i - 1)) || inst !== mem_word(32'h3000 + 32'(4 * (i - 1))))
          $display("FAIL stream_inst%0d: got %h@%h want %h@%h", i, inst, inst_pc,
                   mem_word(32'h3000 + 32'(4 * (i - 1))), 32'h3000 + 32'(4 * (i - 1))); else n_pass++;
      end
    end
  endtask

  task automatic test_ack_delay();
    apply_reset();
    imem_ack = 1'b0;
    next();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || inst_valid !== 1'b0)
        $display("FAIL ackdly_hold%0d: got req %b addr %h valid %b want 1 3000 0", i, imem_req, imem_addr, inst_valid); else n_pass++;
      next();
    end
    imem_ack = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) $display("FAIL ackdly_last: got %b/%h want 1/3000", imem_req, imem_addr); else n_pass++;
    next();
    imem_ack = 1'b0;
    #1;
    n_total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3000 || inst !== mem_word(32'h3000))
      $display("FAIL ackdly_data: got %b %h@%h want 1 %h@3000", inst_valid, inst, inst_pc, mem_word(32'h3000)); else n_pass++;
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req%0d: got %b want 0", i, imem_req); else n_pass++;
      n_total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3000 || inst !== mem_word(32'h3000))
        $display("FAIL stall_hold%0d: got %b %h@%h want 1 %h@3000", i, inst_valid, inst, inst_pc, mem_word(32'h3000)); else n_pass++;
      next();
    end
    stall = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) $display("FAIL stall_resume: got %b/%h want 1/3004", imem_req, imem_addr); else n_pass++;
    next();
    n_total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3004) $display("FAIL stall_next: got %b@%h want 1@3004", inst_valid, inst_pc); else n_pass++;
  endtask

  task automatic test_redirect_drain();
    apply_reset();
    imem_ack = 1'b1;
    next(); next(); next();
    imem_ack = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) $display("FAIL redir_pend: got %b/%h want 1/3008", imem_req, imem_addr); else n_pass++;
    next();
    redirect_valid = 1'b1; redirect_pc = 32'h3100;
    next();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || inst_valid !== 1'b0)
      $display("FAIL redir_drain: got req %b addr %h valid %b want 1 3008 0", imem_req, imem_addr, inst_valid); else n_pass++;
    imem_ack = 1'b1;
    next();
    #1;
    n_total++; if (imem_addr !== 32'h3100 || inst_valid !== 1'b0)
      $display("FAIL redir_target: got addr %h valid %b want 3100 0", imem_addr, inst_valid); else n_pass++;
    next();
    n_total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3100 || inst !== mem_word(32'h3100))
      $display("FAIL redir_word: got %b %h@%h want 1 %h@3100", inst_valid, inst, inst_pc, mem_word(32'h3100)); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h3102;
    next();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (misalign !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h3100)
      $display("FAIL misalign_pulse: got mis %b valid %b addr %h want 1 0 3100", misalign, inst_valid, imem_addr); else n_pass++;
    next();
    n_total++; if (misalign !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h3100)
      $display("FAIL misalign_after: got mis %b valid %b pc %h want 0 1 3100", misalign, inst_valid, inst_pc); else n_pass++;
  endtask

  task automatic test_halt();
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3200;
    next();
    halt = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || misalign !== 1'b0)
        $display("FAIL halt_hold%0d: got halted %b req %b valid %b mis %b want 1 0 0 0", i, halted, imem_req, inst_valid, misalign); else n_pass++;
      next();
    end
    #2 reset = 1'b0;
    #1;
    n_total++; if (halted !== 1'b0 || imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || misalign !== 1'b0)
      $display("FAIL async_reset: got halted %b req %b valid %b inst %h pc %h mis %b want all 0",
               halted, imem_req, inst_valid, inst, inst_pc, misalign); else n_pass++;
  endtask

  task automatic test_halt_pending();
    apply_reset();
    imem_ack = 1'b0;
    next();
    halt = 1'b1;
    next();
    halt = 1'b0;
    #1;
    n_total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000)
      $display("FAIL halt_drain: got halted %b req %b addr %h want 0 1 3000", halted, imem_req, imem_addr); else n_pass++;
    imem_ack = 1'b1;
    next();
    #1;
    n_total++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL halt_done: got halted %b req %b valid %b want 1 0 0", halted, imem_req, inst_valid); else n_pass++;
    imem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    imem_ack = 1'b1;
    next();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h want fffffffc", imem_addr); else n_pass++;
    next();
    #1;
    n_total++; if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC || inst_pc4 !== 32'h0)
      $display("FAIL wrap_zero: got addr %h pc %h pc4 %h want 0 fffffffc 0", imem_addr, inst_pc, inst_pc4); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_next, pend_addr, xfer_addr, cur_pc, cur_inst, tgt;
    logic        pend, xfer, frozen, redir;
    apply_reset();
    next();
    exp_next = 32'h3000;
    pend     = 1'b0;
    pend_addr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      imem_ack = ($urandom_range(2) != 0);
      stall    = ($urandom_range(3) == 0);
      redir    = ($urandom_range(15) == 0);
      tgt      = 32'h3000 + 32'($urandom_range(1023));
      redirect_valid = redir;
      redirect_pc    = tgt;
      #1;
      if (pend) begin
        n_total++; if (imem_req !== 1'b1 || imem_addr !== pend_addr)
          $display("FAIL rnd_stable c%0d: got %b/%h want 1/%h", cyc, imem_req, imem_addr, pend_addr); else n_pass++;
      end
      frozen = inst_valid && stall;
      if (frozen) begin
        n_total++; if (imem_req !== 1'b0) $display("FAIL rnd_stall_req c%0d: got %b want 0", cyc, imem_req); else n_pass++;
      end
      xfer      = imem_req && imem_ack;
      xfer_addr = imem_addr;
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
      cur_pc    = inst_pc;
      cur_inst  = inst;
      next();
      if (redir) begin
        n_total++; if (inst_valid !== 1'b0 || misalign !== (tgt[1:0] != 2'b00))
          $display("FAIL rnd_redir c%0d: got valid %b mis %b want 0 %b", cyc, inst_valid, misalign, tgt[1:0] != 2'b00); else n_pass++;
        exp_next = {tgt[31:2], 2'b00};
      end else begin
        n_total++; if (misalign !== 1'b0) $display("FAIL rnd_mis c%0d: got %b want 0", cyc, misalign); else n_pass++;
        if (frozen) begin
          n_total++; if (inst_valid !== 1'b1 || inst_pc !== cur_pc || inst !== cur_inst)
            $display("FAIL rnd_frozen c%0d: got %b %h@%h want 1 %h@%h", cyc, inst_valid, inst, inst_pc, cur_inst, cur_pc); else n_pass++;
        end else if (inst_valid) begin
          n_total++; if (!xfer || inst_pc !== xfer_addr)
            $display("FAIL rnd_src c%0d: got pc %h xfer %b want pc %h xfer 1", cyc, inst_pc, xfer, xfer_addr); else n_pass++;
          n_total++; if (inst_pc !== exp_next) $display("FAIL rnd_order c%0d: got %h want %h", cyc, inst_pc, exp_next); else n_pass++;
          n_total++; if (inst !== mem_word(inst_pc) || inst_pc4 !== inst_pc + 32'd4)
            $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", cyc, inst, inst_pc4, mem_word(inst_pc), inst_pc + 32'd4); else n_pass++;
          exp_next = inst_pc + 32'd4;
        end
      end
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want run to complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_ack_delay();
    test_stall();
    test_redirect_drain();
    test_halt();
    test_halt_pending();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
